// File: rtl/lcd_write_ctrl.sv
// Converts CPU writes of the io_lcd register into timed HD44780 bus writes.
// Define LCD_INIT_SEQ_EN to issue the standard init sequence automatically after power-up.
module lcd_write_ctrl #(
  parameter int unsigned T_PWRUP     = 750000,
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_PULSE     = 25,
  parameter int unsigned T_HOLD      = 4,
  parameter int unsigned T_EXEC      = 2500,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] io_lcd_i,
  output logic        lcd_on_o,
  output logic        lcd_blon_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o,
  output logic        busy_o,
  output logic        ready_o,
  output logic        ovf_o
);

  typedef enum logic [2:0] {
    StPwrup,
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StExec
`ifdef LCD_INIT_SEQ_EN
    , StInit
`endif
  } state_e;

  localparam logic [CNT_W-1:0] LdPwrup = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] LdSetup = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LdPulse = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LdHold  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LdExec  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LdLong  = CNT_W'(T_EXEC_LONG - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stb_q;
  logic             pend_vld_q, pend_vld_d;
  logic [8:0]       pend_q, pend_d;
  logic [8:0]       txn_q, txn_d;       // {RS, DATA} of the transaction on the bus
  logic             en_q, en_d;
  logic             on_q, blon_q;
  logic             ready_q, ready_d;
  logic             ovf_q, ovf_d;
  logic             req, pop, is_long;
  logic             unused_bits;

`ifdef LCD_INIT_SEQ_EN
  logic [1:0] init_idx_q, init_idx_d;
  logic       init_act_q, init_act_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    unique case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction
`endif

  assign unused_bits = ^io_lcd_i[28:9];
  assign req         = io_lcd_i[29] != stb_q;
  // Clear and return-home need the long execution wait.
  assign is_long     = !txn_q[8] && (txn_q[7:0] == 8'h01 || txn_q[7:0] == 8'h02);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txn_d   = txn_q;
    ready_d = ready_q;
    pop     = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    init_idx_d = init_idx_q;
    init_act_d = init_act_q;
`endif
    unique case (state_q)
      StPwrup: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef LCD_INIT_SEQ_EN
          state_d    = StInit;
          init_idx_d = 2'd0;
`else
          state_d = StIdle;
          ready_d = 1'b1;
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      StInit: begin
        state_d    = StSetup;
        cnt_d      = LdSetup;
        txn_d      = {1'b0, init_cmd(init_idx_q)};
        init_act_d = 1'b1;
      end
`endif
      StIdle: begin
        if (pend_vld_q) begin
          pop     = 1'b1;
          state_d = StSetup;
          cnt_d   = LdSetup;
          txn_d   = pend_q;
        end
      end
      StSetup: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = StPulse;
          cnt_d   = LdPulse;
        end
      end
      StPulse: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = StHold;
          cnt_d   = LdHold;
        end
      end
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = StExec;
          cnt_d   = is_long ? LdLong : LdExec;
        end
      end
      StExec: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef LCD_INIT_SEQ_EN
          if (!init_act_q) begin
            state_d = StIdle;
          end else if (init_idx_q == 2'd3) begin
            state_d    = StIdle;
            ready_d    = 1'b1;
            init_act_d = 1'b0;
          end else begin
            state_d    = StInit;
            init_idx_d = init_idx_q + 2'd1;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StPwrup;
    endcase
    en_d = (state_d == StPulse);
  end

  // One-deep pending buffer; a slot freed by a pop on the same edge can be refilled.
  always_comb begin
    pend_vld_d = pend_vld_q & ~pop;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    if (req) begin
      if (!pend_vld_q || pop) begin
        pend_vld_d = 1'b1;
        pend_d     = io_lcd_i[8:0];
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StPwrup;
      cnt_q      <= LdPwrup;
      stb_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      txn_q      <= '0;
      en_q       <= 1'b0;
      on_q       <= 1'b0;
      blon_q     <= 1'b0;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      init_idx_q <= 2'd0;
      init_act_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stb_q      <= io_lcd_i[29];
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      txn_q      <= txn_d;
      en_q       <= en_d;
      on_q       <= io_lcd_i[31];
      blon_q     <= io_lcd_i[30];
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
`ifdef LCD_INIT_SEQ_EN
      init_idx_q <= init_idx_d;
      init_act_q <= init_act_d;
`endif
    end
  end

  assign lcd_on_o   = on_q;
  assign lcd_blon_o = blon_q;
  assign lcd_en_o   = en_q;
  assign lcd_rs_o   = txn_q[8];
  assign lcd_rw_o   = 1'b0;
  assign lcd_data_o = txn_q[7:0];
  // Masked by reset so every output reads 0 while reset is held.
  assign busy_o     = ~rst_i & ((state_q != StIdle) | pend_vld_q);
  assign ready_o    = ready_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Scoreboard bench for lcd_write_ctrl: driver pushes expected bus writes, a monitor checks timing.
module tb_lcd_write_ctrl;
  localparam int TPw = 10, TSu = 2, TPu = 3, THo = 2, TEx = 5, TLo = 20;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] io_lcd = '0;
  logic on, blon, en, rs, rw, busy, ready, ovf;
  logic [7:0] data;

  always #5 clk = ~clk;

  lcd_write_ctrl #(
    .T_PWRUP(TPw), .T_SETUP(TSu), .T_PULSE(TPu), .T_HOLD(THo),
    .T_EXEC(TEx), .T_EXEC_LONG(TLo), .CNT_W(20)
  ) dut (
    .clk_i(clk), .rst_i(rst), .io_lcd_i(io_lcd),
    .lcd_on_o(on), .lcd_blon_o(blon), .lcd_en_o(en), .lcd_rs_o(rs), .lcd_rw_o(rw),
    .lcd_data_o(data), .busy_o(busy), .ready_o(ready), .ovf_o(ovf)
  );

  int checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  logic ovf_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic int exec_len(input logic [8:0] t);
    return (!t[8] && (t[7:0] == 8'h01 || t[7:0] == 8'h02)) ? TLo : TEx;
  endfunction

  // Monitor: one bus write = EN pulse, hold, exec, then either idle or the next write.
  int mon_st = 0, hi = 0, lo = 0, cur_len = 0;
  logic [8:0] cur = '0;

  task start_txn();
    if (exp_q.size() == 0) begin
      fail_now("unexpected_en");
      cur = {rs, data};
    end else begin
      cur = exp_q.pop_front();
      chk("rsdata_rise", {23'b0, rs, data}, {23'b0, cur});
    end
    chk("rw_zero", rw, 0);
    cur_len = exec_len(cur);
    hi = 1;
    mon_st = 1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_st = 0;
    end else begin
      case (mon_st)
        0: if (en === 1'b1) start_txn();
        1: begin
          if (en) begin
            hi++;
            chk("rsdata_pulse", {23'b0, rs, data}, {23'b0, cur});
          end else begin
            chk("pulse_len", hi, TPu);
            lo = 1;
            mon_st = 2;
          end
        end
        default: begin
          lo++;
          if (en) begin
            chk("gap_len", lo, THo + cur_len + TSu + 2);
            start_txn();
          end else if (!busy) begin
            chk("busy_fall", lo, THo + cur_len + 1);
            chk("rsdata_idle", {23'b0, rs, data}, {23'b0, cur});
            mon_st = 0;
          end else begin
            if (lo <= THo + cur_len + 1)
              chk("rsdata_stable", {23'b0, rs, data}, {23'b0, cur});
            if (lo > THo + TLo + TSu + 8) begin
              fail_now("monitor_timeout");
              mon_st = 0;
            end
          end
        end
      endcase
    end
  end

  // Caller is at a negedge; the request is seen on the following posedge.
  task automatic toggle(input logic o, input logic b, input logic [8:0] t, input logic accept);
    io_lcd = {o, b, ~io_lcd[29], 20'b0, t};
    if (accept) exp_q.push_back(t);
    else ovf_exp = 1'b1;
    @(negedge clk);
    chk("lcd_on", on, o);
    chk("lcd_blon", blon, b);
    chk("ovf", ovf, ovf_exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || en) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_now("wait_idle_timeout");
    @(negedge clk);
  endtask

  task automatic wait_en();
    int n = 0;
    while (!en && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("wait_en_timeout");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset_outputs", {23'b0, en, rs, rw, data, on, blon, busy, ready, ovf}, 0);
    exp_q.delete();
    ovf_exp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
`endif
    #1;
    chk("pwrup_busy0", busy, 1);
    chk("pwrup_ready0", ready, 0);
    for (int k = 1; k < TPw; k++) begin
      @(negedge clk);
      chk("pwrup_busy", busy, 1);
      chk("pwrup_ready", ready, 0);
    end
    @(negedge clk);
`ifdef LCD_INIT_SEQ_EN
    begin
      int n = 0;
      chk("init_ready_late", ready, 0);
      while (!ready && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("init_ready", ready, 1);
      chk("init_drained", exp_q.size(), 0);
    end
`else
    chk("ready_rise", ready, 1);
    chk("idle_after_pwrup", busy, 0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [8:0] t;
    logic [8:0] t2;
    do_reset();

    // Single data write, latency and on/blon pass-through
    wait_idle();
    toggle(1'b1, 1'b0, 9'h141, 1'b1);
    n = 1;
    while (!en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("en_latency", n, TSu + 2);
    wait_idle();

    // Long versus short execution
    toggle(1'b1, 1'b1, 9'h001, 1'b1); wait_idle();
    toggle(1'b1, 1'b1, 9'h080, 1'b1); wait_idle();
    toggle(1'b1, 1'b0, 9'h002, 1'b1); wait_idle();
    toggle(1'b0, 1'b1, 9'h101, 1'b1); wait_idle();

    // Three back-to-back requests: third overflows, ovf sticky
    toggle(1'b1, 1'b0, 9'h131, 1'b1);
    toggle(1'b1, 1'b0, 9'h001, 1'b1);
    toggle(1'b1, 1'b0, 9'h133, 1'b0);
    wait_idle();
    chk("ovf_sticky", ovf, 1);
    toggle(1'b1, 1'b0, 9'h034, 1'b1);
    wait_idle();
    chk("ovf_sticky2", ovf, 1);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      t[8] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: t[7:0] = 8'h01;
        1: t[7:0] = 8'h02;
        default: t[7:0] = 8'($urandom);
      endcase
      t2 = 9'($urandom);
      toggle(1'($urandom), 1'($urandom), t, 1'b1);
      if (mode == 2) begin
        wait_en();
        toggle(1'($urandom), 1'($urandom), t2, 1'b1);
        toggle(1'($urandom), 1'($urandom), ~t2, 1'b0);
      end
      wait_idle();
    end

    // Reset during PULSE aborts the write and is not replayed
    toggle(1'b1, 1'b1, 9'h155, 1'b1);
    wait_en();
    do_reset();
    repeat (40) @(negedge clk);
    chk("no_replay_queue", exp_q.size(), 0);
    chk("no_replay_busy", busy, 0);
    chk("ovf_cleared", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
